// File: rtl/tron_round_ctrl_pkg.sv
// rtl/tron_round_ctrl_pkg.sv - shared round-controller encodings and timing defaults
package tron_round_ctrl_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CLEAR      = 3'd1;
  localparam logic [2:0] ST_COUNTDOWN  = 3'd2;
  localparam logic [2:0] ST_PLAY       = 3'd3;
  localparam logic [2:0] ST_PAUSE      = 3'd4;
  localparam logic [2:0] ST_ROUND_OVER = 3'd5;
  localparam logic [2:0] ST_MATCH_OVER = 3'd6;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int TICK_DIV_DEFAULT  = 2500000;
  localparam int SEC_DIV_DEFAULT   = 25000000;
  localparam int HOLD_SEC_DEFAULT  = 2;
  localparam int WIN_SCORE_DEFAULT = 5;

  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_score_t;

  function automatic logic [6:0] bcd_value(input bcd_score_t s);
    return ({3'b000, s.tens} * 7'd10) + {3'b000, s.units};
  endfunction

endpackage

// File: rtl/tron_bcd_score.sv
// rtl/tron_bcd_score.sv - one player's two-digit BCD score, saturating at 99
module tron_bcd_score
  import tron_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc && !(tens == BCD_NINE && units == BCD_NINE)) begin
      if (units == BCD_NINE) begin
        units <= 4'd0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tron_round_ctrl.sv
// rtl/tron_round_ctrl.sv - round/match sequencing for the tron game: countdown, step timing, pause, scoring
module tron_round_ctrl
  import tron_round_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int SEC_DIV   = SEC_DIV_DEFAULT,
  parameter int HOLD_SEC  = HOLD_SEC_DEFAULT,
  parameter int WIN_SCORE = WIN_SCORE_DEFAULT
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       crash_valid,
  input  logic       crash_p1,
  input  logic       crash_p2,
  output logic       step_en,
  output logic       arena_clear,
  output logic [2:0] game_state,
  output logic [1:0] countdown,
  output logic [3:0] p1_score_tens,
  output logic [3:0] p1_score_units,
  output logic [3:0] p2_score_tens,
  output logic [3:0] p2_score_units,
  output logic [1:0] winner
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int HOLD_W = (HOLD_SEC > 1) ? $clog2(HOLD_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SEC - 1);
  localparam logic [6:0]        WIN_BIN   = 7'(WIN_SCORE);

  logic [2:0]        state;
  logic              start_prev, pause_prev;
  logic [TICK_W-1:0] tick_cnt;
  logic [SEC_W-1:0]  sec_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        cd_digit;
  logic [1:0]        win_q;
  logic              start_edge, pause_edge, sec_done;
  logic              score_clr, p1_inc, p2_inc, p1_won, p2_won;

  assign start_edge = start_btn & ~start_prev;
  assign pause_edge = pause_btn & ~pause_prev;
  assign sec_done   = (sec_cnt == SEC_LAST);

  assign score_clr = start_edge & ((state == ST_IDLE) | (state == ST_MATCH_OVER));
  assign p1_inc    = (state == ST_PLAY) & crash_valid & crash_p2 & ~crash_p1;
  assign p2_inc    = (state == ST_PLAY) & crash_valid & crash_p1 & ~crash_p2;

  tron_bcd_score u_p1_score (
    .clk   (clk_25MHz),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (p1_inc),
    .tens  (p1_score_tens),
    .units (p1_score_units)
  );

  tron_bcd_score u_p2_score (
    .clk   (clk_25MHz),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (p2_inc),
    .tens  (p2_score_tens),
    .units (p2_score_units)
  );

  assign p1_won = bcd_value(bcd_score_t'({p1_score_tens, p1_score_units})) >= WIN_BIN;
  assign p2_won = bcd_value(bcd_score_t'({p2_score_tens, p2_score_units})) >= WIN_BIN;

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
      tick_cnt   <= '0;
      sec_cnt    <= '0;
      hold_cnt   <= '0;
      cd_digit   <= 2'd0;
      win_q      <= WIN_NONE;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      case (state)
        ST_IDLE: if (start_edge) state <= ST_CLEAR;
        ST_CLEAR: begin
          state    <= ST_COUNTDOWN;
          cd_digit <= 2'd3;
          sec_cnt  <= '0;
        end
        ST_COUNTDOWN: begin
          if (sec_done) begin
            sec_cnt <= '0;
            if (cd_digit == 2'd1) begin
              state    <= ST_PLAY;
              tick_cnt <= '0;
            end else begin
              cd_digit <= cd_digit - 2'd1;
            end
          end else begin
            sec_cnt <= sec_cnt + SEC_W'(1);
          end
        end
        // A crash outranks a pause pressed in the same cycle.
        ST_PLAY: begin
          if (crash_valid) begin
            state    <= ST_ROUND_OVER;
            sec_cnt  <= '0;
            hold_cnt <= '0;
          end else if (pause_edge) begin
            state <= ST_PAUSE;
          end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
          end
        end
        ST_PAUSE: if (pause_edge) state <= ST_PLAY;
        ST_ROUND_OVER: begin
          if (sec_done) begin
            sec_cnt <= '0;
            if (hold_cnt == HOLD_LAST) begin
              if (p1_won || p2_won) begin
                state <= ST_MATCH_OVER;
                win_q <= p1_won ? WIN_P1 : WIN_P2;
              end else begin
                state <= ST_CLEAR;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end else begin
            sec_cnt <= sec_cnt + SEC_W'(1);
          end
        end
        ST_MATCH_OVER: begin
          if (start_edge) begin
            state <= ST_CLEAR;
            win_q <= WIN_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A step due in the cycle that pauses is withheld and fires on resume instead.
  assign step_en     = ~rst & (state == ST_PLAY) & (tick_cnt == TICK_LAST)
                     & ~(pause_edge & ~crash_valid);
  assign arena_clear = ~rst & (state == ST_CLEAR);
  assign game_state  = state;
  assign countdown   = (state == ST_COUNTDOWN) ? cd_digit : 2'd0;
  assign winner      = win_q;

endmodule
